// File: rtl/led_fill_blink_ctrl.sv
// LED fill/ping-pong pattern generator with a blinking "DE2-FPGA" seven-segment banner.
// Step and blink timing are enable pulses in the CLOCK_50 domain.
module led_fill_blink_ctrl #(
  parameter int N_LED     = 18,
  parameter int STEP_DIV  = 27777778,
  parameter int BLINK_DIV = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             PAUSE,
  input  logic             BLINK_EN,
  output logic [N_LED-1:0] LEDR,
  output logic [6:0]       HEX7,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0,
  output logic             STEP_TICK
);

  localparam int H       = N_LED / 2;
  localparam int LVL_W   = $clog2(H + 1);
  localparam int STEP_W  = $clog2(STEP_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [LVL_W-1:0] LVL_H = LVL_W'(H);
  localparam logic [55:0] MSG = {7'b0100001, 7'b0000110, 7'b0100100, 7'b0111111,
                                 7'b0001110, 7'b0001100, 7'b0000010, 7'b0001000};
  localparam logic [55:0] BLANK = '1;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [STEP_W-1:0]  step_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [LVL_W-1:0]   level;
  logic [1:0]         mode_q;
  dir_t               dir;
  logic [N_LED-1:0]   leds_p1;
  logic [55:0]        hex_p1;

  function automatic logic [N_LED-1:0] decode_leds(input logic [LVL_W-1:0] lvl,
                                                    input logic [1:0] m);
    logic [N_LED-1:0] v;
    int l;
    l = int'(lvl);
    v = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (m == 2'b01) v[i] = (i >= H - l) && (i < H + l);
      else            v[i] = (i < l) || (i >= N_LED - l);
    end
    return v;
  endfunction

  assign STEP_TICK = !PAUSE && (step_cnt == STEP_W'(STEP_DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      step_cnt <= '0;
    end else if (!PAUSE) begin
      step_cnt <= STEP_TICK ? '0 : step_cnt + STEP_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // The freshly sampled MODE decides this tick's update; arriving from another
  // mode into ping-pong always starts going up.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      level  <= '0;
      dir    <= DIR_UP;
      mode_q <= 2'b00;
    end else if (STEP_TICK) begin
      mode_q <= MODE;
      case (MODE)
        2'b00, 2'b01: level <= (level == LVL_H) ? '0 : level + LVL_W'(1);
        2'b10: begin
          if (mode_q != 2'b10 || dir == DIR_UP) begin
            if (level == LVL_H) begin
              level <= LVL_H - LVL_W'(1);
              dir   <= DIR_DOWN;
            end else begin
              level <= level + LVL_W'(1);
              dir   <= DIR_UP;
            end
          end else if (level == '0) begin
            level <= LVL_W'(1);
            dir   <= DIR_UP;
          end else begin
            level <= level - LVL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      leds_p1 <= '0;
      hex_p1  <= BLANK;
    end else begin
      leds_p1 <= decode_leds(level, mode_q);
      hex_p1  <= (!BLINK_EN || blink_phase) ? MSG : BLANK;
    end
  end

  assign LEDR = leds_p1;
  assign HEX7 = hex_p1[55:49];
  assign HEX6 = hex_p1[48:42];
  assign HEX5 = hex_p1[41:35];
  assign HEX4 = hex_p1[34:28];
  assign HEX3 = hex_p1[27:21];
  assign HEX2 = hex_p1[20:14];
  assign HEX1 = hex_p1[13:7];
  assign HEX0 = hex_p1[6:0];

endmodule

// File: tb/tb_led_fill_blink_ctrl.sv
// Directed bench for led_fill_blink_ctrl with N_LED=6, STEP_DIV=4, BLINK_DIV=3.
module tb_led_fill_blink_ctrl;

  localparam int N_LED     = 6;
  localparam int STEP_DIV  = 4;
  localparam int BLINK_DIV = 3;
  localparam logic [55:0] MSG = {7'b0100001, 7'b0000110, 7'b0100100, 7'b0111111,
                                 7'b0001110, 7'b0001100, 7'b0000010, 7'b0001000};
  localparam logic [55:0] BLANK = {56{1'b1}};

  logic             CLOCK_50 = 1'b0;
  logic             RST;
  logic [1:0]       MODE;
  logic             PAUSE;
  logic             BLINK_EN;
  logic [N_LED-1:0] LEDR;
  logic [6:0]       HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic             STEP_TICK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  led_fill_blink_ctrl #(.N_LED(N_LED), .STEP_DIV(STEP_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .MODE(MODE), .PAUSE(PAUSE), .BLINK_EN(BLINK_EN),
    .LEDR(LEDR), .HEX7(HEX7), .HEX6(HEX6), .HEX5(HEX5), .HEX4(HEX4),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .STEP_TICK(STEP_TICK)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [55:0] hex_now();
    return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Blink phase flips every BLINK_DIV edges from reset release; HEX lags it by one edge.
  function automatic logic [55:0] hex_model(input int c, input logic en);
    if (!en) return MSG;
    return ((((c - 1) / BLINK_DIV) % 2) == 1) ? MSG : BLANK;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge CLOCK_50);
    cyc++;
  endtask

  task automatic wait_tick(input int exp_gap);
    int n;
    n = 0;
    do begin
      nclk();
      n++;
    end while (!STEP_TICK && n < 50);
    check("tick_gap", 64'(n), 64'(exp_gap));
  endtask

  task automatic do_step(input string tag, input int exp_gap, input logic [N_LED-1:0] exp_led);
    wait_tick(exp_gap);
    check({tag, "_hex"}, 64'(hex_now()), 64'(hex_model(cyc, BLINK_EN)));
    nclk();
    check({tag, "_tick_once"}, 64'(STEP_TICK), 64'(1'b0));
    nclk();
    check({tag, "_led"}, 64'(LEDR), 64'(exp_led));
  endtask

  initial begin
    logic [N_LED-1:0] seq_in  [8];
    logic [N_LED-1:0] seq_out [4];
    logic [N_LED-1:0] seq_pp  [7];
    seq_in  = '{6'b100001, 6'b110011, 6'b111111, 6'b000000,
                6'b100001, 6'b110011, 6'b111111, 6'b000000};
    seq_out = '{6'b001100, 6'b011110, 6'b111111, 6'b000000};
    seq_pp  = '{6'b100001, 6'b110011, 6'b111111, 6'b110011,
                6'b100001, 6'b000000, 6'b100001};

    RST = 1'b1; MODE = 2'b00; PAUSE = 1'b0; BLINK_EN = 1'b1;
    nclk(); nclk();
    check("rst_led", 64'(LEDR), 64'd0);
    check("rst_hex", 64'(hex_now()), 64'(BLANK));
    check("rst_tick", 64'(STEP_TICK), 64'd0);

    RST = 1'b0; cyc = 0;
    for (int k = 0; k < 8; k++) do_step("fill_in", (k == 0) ? 3 : 2, seq_in[k]);

    MODE = 2'b01;
    for (int k = 0; k < 4; k++) do_step("fill_out", 2, seq_out[k]);

    MODE = 2'b10;
    for (int k = 0; k < 7; k++) do_step("pingpong", 2, seq_pp[k]);
    do_step("pp_to_2", 2, 6'b110011);

    PAUSE = 1'b1;
    for (int k = 0; k < 20; k++) begin
      nclk();
      check("pause_tick", 64'(STEP_TICK), 64'd0);
      check("pause_led", 64'(LEDR), 64'(6'b110011));
      check("pause_hex", 64'(hex_now()), 64'(hex_model(cyc, 1'b1)));
    end
    PAUSE = 1'b0;
    do_step("resume", 2, 6'b111111);

    MODE = 2'b00; BLINK_EN = 1'b0;
    do_step("steady_a", 2, 6'b000000);
    do_step("steady_b", 2, 6'b100001);
    MODE = 2'b11;
    do_step("freeze_a", 2, 6'b100001);
    do_step("freeze_b", 2, 6'b100001);

    MODE = 2'b00; BLINK_EN = 1'b1;
    do_step("pre_rst", 2, 6'b110011);
    check("pre_rst_hex", 64'(hex_now()), 64'(MSG));
    #2 RST = 1'b1;
    #1;
    check("async_led", 64'(LEDR), 64'd0);
    check("async_hex", 64'(hex_now()), 64'(BLANK));
    check("async_tick", 64'(STEP_TICK), 64'd0);
    nclk(); nclk();
    check("rst_hold_led", 64'(LEDR), 64'd0);

    RST = 1'b0; cyc = 0;
    wait_tick(3);
    check("restart_led", 64'(LEDR), 64'd0);
    check("restart_hex_blank", 64'(hex_now()), 64'(BLANK));
    nclk();
    check("restart_hex_msg", 64'(hex_now()), 64'(MSG));
    nclk();
    check("restart_led1", 64'(LEDR), 64'(6'b100001));
    do_step("refill_2", 2, 6'b110011);
    do_step("refill_3", 2, 6'b111111);
    MODE = 2'b10;
    do_step("enter_pp_at_h", 2, 6'b110011);
    do_step("pp_down", 2, 6'b100001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
